// File: rtl/reduce_accum_amisha_if.sv
// Operand/result handshake bundle for reduce_accum_amisha.
// The producer/consumer side uses master; the fold block uses slave.
interface reduce_accum_amisha_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       mode_amisha;
  logic             flush_amisha;
  logic             in_valid_amisha;
  logic             in_ready_amisha;
  logic [WIDTH-1:0] in_data_amisha;
  logic             out_valid_amisha;
  logic             out_ready_amisha;
  logic [WIDTH-1:0] out_data_amisha;
  logic             out_zero_amisha;
  logic             out_allones_amisha;
  logic             busy_amisha;

  modport master (
    output mode_amisha, flush_amisha, in_valid_amisha, in_data_amisha, out_ready_amisha,
    input  in_ready_amisha, out_valid_amisha, out_data_amisha, out_zero_amisha,
           out_allones_amisha, busy_amisha
  );

  modport slave (
    input  mode_amisha, flush_amisha, in_valid_amisha, in_data_amisha, out_ready_amisha,
    output in_ready_amisha, out_valid_amisha, out_data_amisha, out_zero_amisha,
           out_allones_amisha, busy_amisha
  );
endinterface

// File: rtl/reduce_accum_amisha.sv
// Sequential bitwise fold of NUM_OPERANDS words (AND/OR/XOR/NAND) with
// valid/ready on both sides and a registered result plus zero/all-ones flags.
module reduce_accum_amisha #(
  parameter int WIDTH        = 8,
  parameter int NUM_OPERANDS = 3
) (
  input logic                 clk_amisha,
  input logic                 reset_amisha,
  reduce_accum_amisha_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_OPERANDS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPERANDS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_e;
  typedef enum logic [1:0] {MODE_AND, MODE_OR, MODE_XOR, MODE_NAND} mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;
  logic             allones_q, allones_d;
  logic             busy_q, busy_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] acc_fold;
  logic [WIDTH-1:0] result;

  assign in_ready = (state_q != HOLD) && !bus.flush_amisha;
  assign accept   = bus.in_valid_amisha && in_ready;

  // NAND folds with AND; the inversion is applied only to the final result.
  always_comb begin
    case (mode_q)
      MODE_OR:  acc_fold = acc_q | bus.in_data_amisha;
      MODE_XOR: acc_fold = acc_q ^ bus.in_data_amisha;
      default:  acc_fold = acc_q & bus.in_data_amisha;
    endcase
    result = (mode_q == MODE_NAND) ? ~acc_fold : acc_fold;
  end

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path can infer a latch.
    state_d     = state_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    zero_d      = zero_q;
    allones_d   = allones_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = bus.in_data_amisha;
          mode_d  = mode_e'(bus.mode_amisha);
          cnt_d   = CNT_W'(1);
          busy_d  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bus.flush_amisha) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (accept) begin
          acc_d = acc_fold;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            out_data_d  = result;
            out_valid_d = 1'b1;
            zero_d      = (result == '0);
            allones_d   = (result == '1);
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_valid_q && bus.out_ready_amisha) begin
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_amisha) begin
    // NOTE: state uses non-blocking assignment so every register samples pre-edge values.
    if (reset_amisha) begin
      state_q     <= IDLE;
      mode_q      <= MODE_AND;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      allones_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      allones_q   <= allones_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready_amisha    = in_ready;
  assign bus.out_valid_amisha   = out_valid_q;
  assign bus.out_data_amisha    = out_data_q;
  assign bus.out_zero_amisha    = zero_q;
  assign bus.out_allones_amisha = allones_q;
  assign bus.busy_amisha        = busy_q;
endmodule

// File: tb/tb_reduce_accum_amisha.sv
// Directed plus randomized checks of reduce_accum_amisha at three parameter
// points against an array-based reference fold.
module tb_reduce_accum_amisha;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reduce_accum_amisha_if #(.WIDTH(8))  if0 ();
  reduce_accum_amisha_if #(.WIDTH(1))  if1 ();
  reduce_accum_amisha_if #(.WIDTH(16)) if2 ();

  reduce_accum_amisha #(.WIDTH(8),  .NUM_OPERANDS(3)) u0 (.clk_amisha(clk), .reset_amisha(rst), .bus(if0));
  reduce_accum_amisha #(.WIDTH(1),  .NUM_OPERANDS(2)) u1 (.clk_amisha(clk), .reset_amisha(rst), .bus(if1));
  reduce_accum_amisha #(.WIDTH(16), .NUM_OPERANDS(7)) u2 (.clk_amisha(clk), .reset_amisha(rst), .bus(if2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: fold the operand list in order, invert at the end for NAND, mask to width.
  function automatic logic [15:0] ref_fold(input logic [1:0] m, input logic [15:0] ops[7],
                                           input int n, input int w);
    logic [15:0] mask = (w == 16) ? 16'hFFFF : 16'((32'd1 << w) - 1);
    logic [15:0] r = ops[0];
    for (int i = 1; i < n; i++) begin
      if (m == 2'd1)      r = r | ops[i];
      else if (m == 2'd2) r = r ^ ops[i];
      else                r = r & ops[i];
    end
    if (m == 2'd3) r = ~r;
    return r & mask;
  endfunction

  task automatic push0(input logic [7:0] d, input logic [1:0] m);
    if0.in_valid_amisha = 1'b1;
    if0.in_data_amisha  = d;
    if0.mode_amisha     = m;
    tick();
    if0.in_valid_amisha = 1'b0;
  endtask

  task automatic fold3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [1:0] m);
    push0(a, m);
    push0(b, m);
    push0(c, m);
  endtask

  task automatic check_result0(input string tag, input logic [7:0] exp);
    check({tag, "_valid"},   32'(if0.out_valid_amisha),   32'd1);
    check({tag, "_data"},    32'(if0.out_data_amisha),    32'(exp));
    check({tag, "_zero"},    32'(if0.out_zero_amisha),    32'(exp == 8'h00));
    check({tag, "_allones"}, 32'(if0.out_allones_amisha), 32'(exp == 8'hFF));
  endtask

  task automatic run1();
    logic [15:0] ops[7];
    logic [1:0]  m = 2'($urandom_range(0, 3));
    logic [15:0] exp;
    int          waited = 0;
    for (int i = 0; i < 7; i++) ops[i] = '0;
    for (int i = 0; i < 2; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      ops[i] = 16'($urandom_range(0, 1));
      if1.in_valid_amisha = 1'b1;
      if1.in_data_amisha  = ops[i][0];
      if1.mode_amisha     = (i == 0) ? m : 2'($urandom_range(0, 3));
      tick();
      if1.in_valid_amisha = 1'b0;
    end
    exp = ref_fold(m, ops, 2, 1);
    while (!if1.out_valid_amisha && waited < 4) begin tick(); waited++; end
    check("w1_valid",   32'(if1.out_valid_amisha),   32'd1);
    check("w1_data",    32'(if1.out_data_amisha),    32'(exp));
    check("w1_zero",    32'(if1.out_zero_amisha),    32'(exp == 16'h0));
    check("w1_allones", 32'(if1.out_allones_amisha), 32'(exp == 16'h1));
    repeat ($urandom_range(0, 2)) tick();
    if1.out_ready_amisha = 1'b1;
    tick();
    if1.out_ready_amisha = 1'b0;
    check("w1_release", 32'(if1.out_valid_amisha), 32'd0);
  endtask

  task automatic run2();
    logic [15:0] ops[7];
    logic [1:0]  m = 2'($urandom_range(0, 3));
    logic [15:0] exp;
    int          waited = 0;
    for (int i = 0; i < 7; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      ops[i] = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      if2.in_valid_amisha = 1'b1;
      if2.in_data_amisha  = ops[i];
      if2.mode_amisha     = (i == 0) ? m : 2'($urandom_range(0, 3));
      tick();
      if2.in_valid_amisha = 1'b0;
    end
    exp = ref_fold(m, ops, 7, 16);
    while (!if2.out_valid_amisha && waited < 4) begin tick(); waited++; end
    check("w16_valid",   32'(if2.out_valid_amisha),   32'd1);
    check("w16_data",    32'(if2.out_data_amisha),    32'(exp));
    check("w16_zero",    32'(if2.out_zero_amisha),    32'(exp == 16'h0));
    check("w16_allones", 32'(if2.out_allones_amisha), 32'(exp == 16'hFFFF));
    if2.out_ready_amisha = 1'b1;
    tick();
    if2.out_ready_amisha = 1'b0;
    check("w16_release", 32'(if2.out_valid_amisha), 32'd0);
  endtask

  initial begin
    if0.mode_amisha = 2'd0; if0.flush_amisha = 1'b0; if0.in_valid_amisha = 1'b0;
    if0.in_data_amisha = '0; if0.out_ready_amisha = 1'b1;
    if1.mode_amisha = 2'd0; if1.flush_amisha = 1'b0; if1.in_valid_amisha = 1'b0;
    if1.in_data_amisha = '0; if1.out_ready_amisha = 1'b0;
    if2.mode_amisha = 2'd0; if2.flush_amisha = 1'b0; if2.in_valid_amisha = 1'b0;
    if2.in_data_amisha = '0; if2.out_ready_amisha = 1'b0;

    repeat (2) tick();
    rst = 1'b0;
    check("rst_valid",   32'(if0.out_valid_amisha),   32'd0);
    check("rst_data",    32'(if0.out_data_amisha),    32'd0);
    check("rst_zero",    32'(if0.out_zero_amisha),    32'd0);
    check("rst_allones", 32'(if0.out_allones_amisha), 32'd0);
    check("rst_busy",    32'(if0.busy_amisha),        32'd0);
    check("rst_ready",   32'(if0.in_ready_amisha),    32'd1);

    // AND fold, back-to-back, consumer always ready
    fold3(8'hFF, 8'hF0, 8'h3C, 2'd0);
    check_result0("and", 8'h30);
    check("and_hold_ready", 32'(if0.in_ready_amisha), 32'd0);
    check("and_busy",       32'(if0.busy_amisha),     32'd1);
    tick();
    check("and_idle_valid", 32'(if0.out_valid_amisha), 32'd0);
    check("and_idle_ready", 32'(if0.in_ready_amisha),  32'd1);
    check("and_idle_busy",  32'(if0.busy_amisha),      32'd0);
    check("and_keep_data",  32'(if0.out_data_amisha),  32'h30);

    fold3(8'hFF, 8'hF0, 8'h3C, 2'd1);
    check_result0("or", 8'hFF);
    tick();
    fold3(8'hFF, 8'hF0, 8'h3C, 2'd2);
    check_result0("xor", 8'h33);
    tick();
    fold3(8'hFF, 8'hF0, 8'h3C, 2'd3);
    check_result0("nand", 8'hCF);
    tick();
    push0(8'hFF, 2'd2);
    push0(8'hF0, 2'd0);
    push0(8'h3C, 2'd3);
    check_result0("mode_latch", 8'h33);
    tick();

    // Backpressure: result held, operands and flush refused while HOLD
    if0.out_ready_amisha = 1'b0;
    fold3(8'hFF, 8'hF0, 8'h3C, 2'd0);
    if0.in_valid_amisha = 1'b1;
    if0.in_data_amisha  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      if0.flush_amisha = (i == 2);
      #1;
      check("bp_valid", 32'(if0.out_valid_amisha), 32'd1);
      check("bp_data",  32'(if0.out_data_amisha),  32'h30);
      check("bp_ready", 32'(if0.in_ready_amisha),  32'd0);
      tick();
    end
    if0.in_valid_amisha  = 1'b0;
    if0.flush_amisha     = 1'b0;
    check("bp_after_flush", 32'(if0.out_valid_amisha), 32'd1);
    if0.out_ready_amisha = 1'b1;
    tick();
    check("bp_release_valid", 32'(if0.out_valid_amisha), 32'd0);
    check("bp_release_ready", 32'(if0.in_ready_amisha),  32'd1);
    check("bp_release_busy",  32'(if0.busy_amisha),      32'd0);

    // Bubbles then flush abort the partial fold
    push0(8'hAA, 2'd0);
    for (int i = 0; i < 2; i++) begin
      check("bub_valid", 32'(if0.out_valid_amisha), 32'd0);
      check("bub_busy",  32'(if0.busy_amisha),      32'd1);
      tick();
    end
    if0.flush_amisha    = 1'b1;
    if0.in_valid_amisha = 1'b1;
    if0.in_data_amisha  = 8'h00;
    #1;
    check("flush_ready", 32'(if0.in_ready_amisha), 32'd0);
    tick();
    if0.flush_amisha    = 1'b0;
    if0.in_valid_amisha = 1'b0;
    check("flush_valid", 32'(if0.out_valid_amisha), 32'd0);
    check("flush_busy",  32'(if0.busy_amisha),      32'd0);
    fold3(8'h0F, 8'hF0, 8'hFF, 2'd0);
    check_result0("post_flush", 8'h00);
    tick();

    // Reset mid-accumulation and during HOLD
    push0(8'h12, 2'd1);
    push0(8'h34, 2'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", 32'(if0.out_valid_amisha), 32'd0);
    check("rst_mid_data",  32'(if0.out_data_amisha),  32'd0);
    check("rst_mid_busy",  32'(if0.busy_amisha),      32'd0);
    fold3(8'h81, 8'h18, 8'h01, 2'd1);
    check_result0("rst_mid_fresh", 8'h99);
    tick();
    if0.out_ready_amisha = 1'b0;
    fold3(8'h55, 8'hFF, 8'hF5, 2'd2);
    check_result0("pre_rst_hold", 8'h5F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_hold_valid",   32'(if0.out_valid_amisha),   32'd0);
    check("rst_hold_data",    32'(if0.out_data_amisha),    32'd0);
    check("rst_hold_zero",    32'(if0.out_zero_amisha),    32'd0);
    check("rst_hold_allones", 32'(if0.out_allones_amisha), 32'd0);
    check("rst_hold_busy",    32'(if0.busy_amisha),        32'd0);
    check("rst_hold_ready",   32'(if0.in_ready_amisha),    32'd1);
    if0.out_ready_amisha = 1'b1;
    fold3(8'hF0, 8'hF0, 8'hF0, 2'd3);
    check_result0("rst_hold_fresh", 8'h0F);
    tick();

    // Parameter sweep with random operands and modes
    for (int t = 0; t < 40; t++) run1();
    for (int t = 0; t < 30; t++) run2();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "simulation time limit");
  end
endmodule

// File: doc/reduce_accum_amisha.md
Name: reduce_accum_amisha

Overview:
Parametrised, sequential successor to the team's 3-input bitwise AND block. Accepts a stream of NUM_OPERANDS words of WIDTH bits, one per handshake. Folds them with a selectable bitwise operator (AND/OR/XOR/NAND) and presents one registered result word with zero/all-ones flags. Sits between an operand producer and a result consumer in the RT-level combinational/datapath library, with valid/ready on both sides.

Parameters:
WIDTH, 8, bit width of each operand and of the result (>=1)
NUM_OPERANDS, 3, operands folded per result (>=2); count register width = clog2(NUM_OPERANDS+1)

Ports:
clk_amisha  input  1  clock; all state updates on the rising edge
reset_amisha  input  1  synchronous, active-high reset
mode_amisha  input  2  00=AND, 01=OR, 10=XOR, 11=NAND (AND fold, inverted at output); sampled with first operand
flush_amisha  input  1  abort a partial accumulation
in_valid_amisha  input  1  operand valid
in_ready_amisha  output  1  block can accept an operand
in_data_amisha  input  WIDTH  operand word
out_valid_amisha  output  1  result valid
out_ready_amisha  input  1  consumer accepts result
out_data_amisha  output  WIDTH  folded result
out_zero_amisha  output  1  out_data_amisha == 0
out_allones_amisha  output  1  out_data_amisha == all ones
busy_amisha  output  1  accumulation in progress or result held

Behaviour:
- Clock and reset: one clock (clk_amisha); reset_amisha is synchronous, active-high.
- Reset: state=IDLE, acc=0, cnt=0, latched mode=00; out_valid/out_data/out_zero/out_allones/busy all 0. Reset dominates flush and handshakes, including mid-accumulation or while HOLD; the held result is discarded.
- Operand accept: in_valid_amisha && in_ready_amisha at a rising edge.
- in_ready_amisha = (state != HOLD) && !flush_amisha (combinational from state and flush). It is 1 in the first cycle after reset release.
- State IDLE:
  - On accept: acc<=in_data, mode latched from mode_amisha, cnt<=1, busy<=1, go ACCUM.
- State ACCUM:
  - On accept: acc<=acc OP in_data (AND for 00/11, OR for 01, XOR for 10), cnt<=cnt+1.
  - On accept with cnt==NUM_OPERANDS-1: go HOLD. In the same edge, out_data<=final value, inverted if latched mode=11, and out_valid<=1. Flags are computed from that final out_data value.
  - Cycles without in_valid_amisha insert bubbles; acc and cnt hold.
  - mode_amisha changes after the first operand are ignored until the next IDLE accept.
- State HOLD:
  - in_ready_amisha=0. out_valid_amisha, out_data_amisha and the flags hold stable until the result is accepted.
  - On out_valid && out_ready: out_valid<=0, busy<=0, cnt<=0, go IDLE. Next accept is possible the following cycle.
- Flush:
  - In ACCUM: go IDLE, cnt<=0, busy<=0. No operand is accepted that cycle (in_ready forced 0). out_* are unchanged (still 0/previous flags, out_valid stays 0).
  - In IDLE: no effect.
  - In HOLD: ignored; the result is not lost.
- Latency and throughput:
  - out_valid_amisha rises the cycle after the last operand is accepted.
  - Minimum spacing is NUM_OPERANDS+1 cycles per result with out_ready held high.
- Arithmetic: purely bitwise, no carries. out_data keeps its last value after the result handshake; out_valid alone qualifies it.
- out_zero/out_allones are registered alongside out_data and are only meaningful while out_valid=1.

Test Plan:
- AND fold: WIDTH=8, N=3, mode=00, operands 0xFF,0xF0,0x3C back-to-back, out_ready=1 -> out_data=0x30 one cycle after the 3rd accept; zero=0, allones=0; IDLE next cycle.
- Modes: same operands with mode=01 -> 0xFF, allones=1. mode=10 -> 0x33. mode=11 -> 0xCF. Changing mode_amisha after the 1st operand does not alter the result.
- Backpressure: out_ready=0 for 5 cycles after result -> in_ready=0, out_valid=1, out_data stable throughout; an in_valid pulse during HOLD is not consumed. Release -> out_valid falls, in_ready=1 the next cycle.
- Bubbles and flush: 0xAA, idle 2 cycles, flush -> IDLE, out_valid never asserts. Then 0x0F,0xF0,0xFF with mode=00 -> 0x00, zero=1.
- Reset mid-operation: reset after 2 operands, and again during HOLD -> all outputs 0 next cycle, busy=0. Next 3-operand sequence produces a correct fresh result.
- Parameter sweep: WIDTH=1, N=2 and WIDTH=16, N=7 with random operands and modes -> every result matches the reference fold.
